// File: rtl/mandelbrot_pkg.sv
// Shared fixed-point constants, FSM encoding and default view window for the Mandelbrot
// coordinate generator.
package mandelbrot_pkg;

    // Fixed-point layout s4.F: 1 sign bit, 4 integer bits, the remainder fractional.
    localparam int FP_S    = 1;
    localparam int FP_I    = 4;
    localparam int DEF_FPW = 27;
    localparam int FP_F    = DEF_FPW - FP_S - FP_I;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    // Default view window (-2.5..1.0, -1.0..1.0) in the DEF_FPW format.
    localparam int WIN_X_MIN = -(5 <<< (FP_F - 1));
    localparam int WIN_X_MAX = 1 <<< FP_F;
    localparam int WIN_Y_MIN = -(1 <<< FP_F);
    localparam int WIN_Y_MAX = 1 <<< FP_F;

endpackage

// File: rtl/mandelbrot_fp_acc.sv
// Registered signed fixed-point accumulator with load priority over add.
// MANDELBROT_COORDS_SAT_EN: saturate on overflow and expose the per-add overflow flag.
module mandelbrot_fp_acc #(
    parameter int FPW = 27
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           load,
    input  logic [FPW-1:0] load_val,
    input  logic           add,
    input  logic [FPW-1:0] step,
    output logic [FPW-1:0] acc
`ifdef MANDELBROT_COORDS_SAT_EN
    ,
    output logic           ovf
`endif
);

    logic [FPW-1:0] nxt;

`ifdef MANDELBROT_COORDS_SAT_EN
    logic [FPW:0] sum;

    assign sum = {acc[FPW-1], acc} + {step[FPW-1], step};
    assign ovf = sum[FPW] ^ sum[FPW-1];

    always_comb begin
        nxt = sum[FPW-1:0];
        if (ovf) begin
            nxt = sum[FPW] ? {1'b1, {(FPW-1){1'b0}}} : {1'b0, {(FPW-1){1'b1}}};
        end
    end
`else
    // The low FPW bits of the widened sum equal a plain two's-complement wrap.
    assign nxt = acc + step;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clk_en) begin
            if (load) begin
                acc <= load_val;
            end else if (add) begin
                acc <= nxt;
            end
        end
    end

endmodule

// File: rtl/mandelbrot_coords_gen.sv
// Raster scanner emitting one fixed-point (x, y) coordinate per pixel as a ready/valid stream.
// MANDELBROT_COORDS_SAT_EN: saturating accumulation plus a sticky ovf output.
module mandelbrot_coords_gen
    import mandelbrot_pkg::*;
#(
    parameter  int HRES = 640,
    parameter  int VRES = 480,
    parameter  int CW   = 12,
    parameter  int AW   = 19,
    parameter  int FPW  = 27,
    parameter  int NCH  = 4,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           init,
    input  logic [FPW-1:0] x0,
    input  logic [FPW-1:0] y0,
    input  logic [FPW-1:0] xs,
    input  logic [FPW-1:0] ys,
    input  logic           out_rdy,
    output logic           out_vld,
    output logic [FPW-1:0] x,
    output logic [FPW-1:0] y,
    output logic [AW-1:0]  adr,
    output logic [CHW-1:0] ch,
    output logic           busy,
    output logic           done
`ifdef MANDELBROT_COORDS_SAT_EN
    ,
    output logic           ovf
`endif
);

    state_t         state;
    logic [CW-1:0]  cnt_x, cnt_y;
    logic [FPW-1:0] x0_q, xs_q, ys_q;
    logic           xfer, eol, last;
    logic           x_load, x_add, y_add;

    assign xfer   = out_vld && out_rdy && (state == ST_RUN);
    assign eol    = (cnt_x == CW'(HRES - 1));
    assign last   = eol && (cnt_y == CW'(VRES - 1));
    assign x_load = init || (xfer && eol && !last);
    assign x_add  = xfer && !eol;
    assign y_add  = xfer && eol && !last;

`ifdef MANDELBROT_COORDS_SAT_EN
    logic x_ovf, y_ovf;
`endif

    mandelbrot_fp_acc #(
        .FPW (FPW)
    ) u_acc_x (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .load     (x_load),
        .load_val (init ? x0 : x0_q),
        .add      (x_add),
        .step     (xs_q),
        .acc      (x)
`ifdef MANDELBROT_COORDS_SAT_EN
        ,
        .ovf      (x_ovf)
`endif
    );

    mandelbrot_fp_acc #(
        .FPW (FPW)
    ) u_acc_y (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .load     (init),
        .load_val (y0),
        .add      (y_add),
        .step     (ys_q),
        .acc      (y)
`ifdef MANDELBROT_COORDS_SAT_EN
        ,
        .ovf      (y_ovf)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            out_vld <= 1'b0;
            adr     <= '0;
            ch      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt_x   <= '0;
            cnt_y   <= '0;
            x0_q    <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
`ifdef MANDELBROT_COORDS_SAT_EN
            ovf     <= 1'b0;
`endif
        end else if (clk_en) begin
            done <= 1'b0;
            // init restarts from any state and wins over a coincident handshake.
            if (init) begin
                x0_q    <= x0;
                xs_q    <= xs;
                ys_q    <= ys;
                cnt_x   <= '0;
                cnt_y   <= '0;
                adr     <= '0;
                ch      <= '0;
                out_vld <= 1'b1;
                busy    <= 1'b1;
                state   <= ST_RUN;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_RUN: begin
                        if (xfer) begin
                            if (last) begin
                                out_vld <= 1'b0;
                                done    <= 1'b1;
                                state   <= ST_FIN;
                            end else begin
                                adr <= adr + 1'b1;
                                ch  <= (ch == CHW'(NCH - 1)) ? '0 : ch + 1'b1;
                                if (eol) begin
                                    cnt_x <= '0;
                                    cnt_y <= cnt_y + 1'b1;
                                end else begin
                                    cnt_x <= cnt_x + 1'b1;
                                end
                            end
                        end
                    end
                    ST_FIN: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
`ifdef MANDELBROT_COORDS_SAT_EN
            if (init) begin
                ovf <= 1'b0;
            end else if ((x_add && x_ovf) || (y_add && y_ovf)) begin
                ovf <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mandelbrot_coords_gen.sv
// Self-checking bench for mandelbrot_coords_gen: table-driven frames, scoreboard queue,
// and hand-written sequences for backpressure, abort, reset, clock-enable and overflow.
module tb_mandelbrot_coords_gen;

    localparam int HRES = 4;
    localparam int VRES = 3;
    localparam int CW   = 12;
    localparam int AW   = 19;
    localparam int FPW  = 27;
    localparam int NCH  = 4;
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic           clk = 1'b0;
    logic           rst, clk_en, init, out_rdy;
    logic [FPW-1:0] x0, y0, xs, ys;
    logic           out_vld, busy, done;
    logic [FPW-1:0] x, y;
    logic [AW-1:0]  adr;
    logic [CHW-1:0] ch;
`ifdef MANDELBROT_COORDS_SAT_EN
    logic           ovf;
`endif

    always #5 clk = ~clk;

    mandelbrot_coords_gen #(
        .HRES (HRES),
        .VRES (VRES),
        .CW   (CW),
        .AW   (AW),
        .FPW  (FPW),
        .NCH  (NCH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .init    (init),
        .x0      (x0),
        .y0      (y0),
        .xs      (xs),
        .ys      (ys),
        .out_rdy (out_rdy),
        .out_vld (out_vld),
        .x       (x),
        .y       (y),
        .adr     (adr),
        .ch      (ch),
        .busy    (busy),
        .done    (done)
`ifdef MANDELBROT_COORDS_SAT_EN
        ,
        .ovf     (ovf)
`endif
    );

    typedef struct {
        logic [FPW-1:0] x;
        logic [FPW-1:0] y;
        int             adr;
        int             ch;
    } pix_t;

    typedef struct {
        int  x0, y0, xs, ys;
        bit  rnd;
        int  last_x, last_y;
    } vec_t;

    pix_t           q[$];
    int             checks = 0;
    int             errors = 0;
    int             m_st = 0;
    logic           m_vld = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int             n_xfer, n_done, last_adr;
    logic [FPW-1:0] last_x, last_y;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [FPW-1:0] fp_add(input logic [FPW-1:0] a, input logic [FPW-1:0] b);
        logic [FPW:0] s;
        s = {a[FPW-1], a} + {b[FPW-1], b};
`ifdef MANDELBROT_COORDS_SAT_EN
        if (s[FPW] != s[FPW-1]) return s[FPW] ? {1'b1, {(FPW-1){1'b0}}} : {1'b0, {(FPW-1){1'b1}}};
`endif
        return s[FPW-1:0];
    endfunction

    task automatic push_frame(input logic [FPW-1:0] fx0, input logic [FPW-1:0] fy0,
                              input logic [FPW-1:0] fxs, input logic [FPW-1:0] fys);
        pix_t p;
        logic [FPW-1:0] cx, cy;
        int a = 0;
        cy = fy0;
        for (int r = 0; r < VRES; r++) begin
            cx = fx0;
            for (int c = 0; c < HRES; c++) begin
                p.x = cx; p.y = cy; p.adr = a; p.ch = a % NCH;
                q.push_back(p);
                a++;
                if (c != HRES - 1) cx = fp_add(cx, fxs);
            end
            if (r != VRES - 1) cy = fp_add(cy, fys);
        end
    endtask

    // Check current outputs against the model, advance the model with the current inputs,
    // then let one clock edge pass.
    task automatic cycle();
        logic xf;
        chk("out_vld", out_vld, m_vld);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        if (done) n_done++;
        if (m_vld) begin
            chk("pending", q.size() > 0, 1);
            if (q.size() > 0) begin
                chk("x", $signed(x), $signed(q[0].x));
                chk("y", $signed(y), $signed(q[0].y));
                chk("adr", adr, q[0].adr);
                chk("ch", ch, q[0].ch);
            end
        end
        xf = m_vld && out_rdy && clk_en && !rst && !init;
        if (rst) begin
            q.delete();
            m_vld = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_st = 0;
        end else if (clk_en) begin
            m_done = 1'b0;
            if (init) begin
                q.delete();
                push_frame(x0, y0, xs, ys);
                m_vld = 1'b1; m_busy = 1'b1; m_st = 1;
            end else if (xf) begin
                last_x = x; last_y = y; last_adr = int'(adr);
                n_xfer++;
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_vld = 1'b0; m_done = 1'b1; m_st = 2;
                end
            end else if (m_st == 2) begin
                m_busy = 1'b0; m_st = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int sx0, input int sy0, input int sxs, input int sys);
        x0 = FPW'(sx0); y0 = FPW'(sy0); xs = FPW'(sxs); ys = FPW'(sys);
        init = 1'b1;
        cycle();
        init = 1'b0;
        n_xfer = 0;
        n_done = 0;
    endtask

    task automatic run_to_idle(input bit rnd, output int n);
        n = 0;
        while (m_st != 0 && n < 400) begin
            out_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle();
            n++;
        end
        chk("frame_timeout", n < 400, 1);
    endtask

    task automatic wait_adr(input int target);
        int n = 0;
        out_rdy = 1'b1;
        while (!(out_vld && int'(adr) == target) && n < 100) begin
            cycle();
            n++;
        end
        chk("wait_adr_timeout", n < 100, 1);
    endtask

    vec_t vecs[3];

    initial begin
        int n;
        logic [FPW-1:0] sx;

        vecs[0] = '{x0: -8388608, y0: -4194304, xs: 2097152, ys: 4194304, rnd: 1'b0,
                    last_x: -2097152, last_y: 4194304};
        vecs[1] = '{x0: 0, y0: 100, xs: 1, ys: -7, rnd: 1'b1, last_x: 3, last_y: 86};
        vecs[2] = '{x0: 1000, y0: -5, xs: -300, ys: 0, rnd: 1'b1, last_x: 100, last_y: -5};

        rst = 1'b1; clk_en = 1'b1; init = 1'b0; out_rdy = 1'b0;
        x0 = '0; y0 = '0; xs = '0; ys = '0;
        n_xfer = 0; n_done = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_adr", adr, 0);
        chk("rst_ch", ch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (3) cycle();

        for (int i = 0; i < 3; i++) begin
            start(vecs[i].x0, vecs[i].y0, vecs[i].xs, vecs[i].ys);
            run_to_idle(vecs[i].rnd, n);
            chk("frame_xfers", n_xfer, HRES * VRES);
            chk("frame_done_pulses", n_done, 1);
            chk("frame_last_adr", last_adr, HRES * VRES - 1);
            chk("frame_last_x", $signed(last_x), vecs[i].last_x);
            chk("frame_last_y", $signed(last_y), vecs[i].last_y);
            if (!vecs[i].rnd) chk("full_rate_cycles", n, HRES * VRES + 1);
        end

        // Backpressure at adr=5.
        start(-8388608, -4194304, 2097152, 4194304);
        wait_adr(5);
        sx = x;
        out_rdy = 1'b0;
        repeat (5) cycle();
        chk("bp_vld", out_vld, 1);
        chk("bp_adr", adr, 5);
        chk("bp_x", $signed(x), $signed(sx));
        out_rdy = 1'b1;
        cycle();
        chk("bp_resume_adr", adr, 6);
        run_to_idle(1'b0, n);
        chk("bp_xfers", n_xfer, HRES * VRES);

        // Abort at adr=7 with a new origin.
        start(-8388608, -4194304, 2097152, 4194304);
        wait_adr(7);
        x0 = '0;
        init = 1'b1;
        cycle();
        init = 1'b0;
        chk("abort_adr", adr, 0);
        chk("abort_x", x, 0);
        chk("abort_ch", ch, 0);
        n_done = 0;
        run_to_idle(1'b0, n);
        chk("abort_done_pulses", n_done, 1);

        // Reset during RUN.
        start(-8388608, -4194304, 2097152, 4194304);
        out_rdy = 1'b1;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_out_vld", out_vld, 0);
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_adr", adr, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (3) cycle();

        // Clock enable held low mid-frame.
        start(-8388608, -4194304, 2097152, 4194304);
        wait_adr(3);
        clk_en = 1'b0;
        repeat (3) cycle();
        chk("clk_en_adr", adr, 3);
        chk("clk_en_x", $signed(x), 2097152 * 3 - 8388608);
        clk_en = 1'b1;
        run_to_idle(1'b0, n);
        chk("clk_en_xfers", n_xfer, HRES * VRES);

        // Overflow on the second pixel.
        start((1 << 26) - 4, 0, 4, 0);
`ifdef MANDELBROT_COORDS_SAT_EN
        chk("ovf_clear", ovf, 0);
`endif
        out_rdy = 1'b1;
        cycle();
`ifdef MANDELBROT_COORDS_SAT_EN
        chk("ovf_x", $signed(x), (1 << 26) - 1);
`else
        chk("ovf_x", $signed(x), -(1 << 26));
`endif
        run_to_idle(1'b0, n);
`ifdef MANDELBROT_COORDS_SAT_EN
        chk("ovf_sticky", ovf, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
